icache_prefetch: RTL and testbench
==================================

ICACHE_PREFETCH -- requirements
Module: icache_prefetch

Interface
REQ-001 SHALL have parameter PF_ENABLE, default 1, meaning 1 = next-line prefetch enabled, 0 = demand fetch only.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port proc_reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port ic_read  input  1  line request from icache memory side; held high until ic_ready.
REQ-005 SHALL have port ic_addr  input  28  line address from icache; stable while ic_read high.
REQ-006 SHALL have port ic_rdata  output  128  line data returned to icache; valid only while ic_ready=1.
REQ-007 SHALL have port ic_ready  output  1  one-cycle pulse completing an icache request.
REQ-008 SHALL have port mem_read  output  1  read request to main memory.
REQ-009 SHALL have port mem_addr  output  28  line address to main memory.
REQ-010 SHALL have port mem_rdata  input  128  memory line data; valid in the cycle mem_ready=1.
REQ-011 SHALL have port mem_ready  input  1  memory completion, one cycle per request.
REQ-012 SHALL have ports pf_issued and pf_hit  output  32 each  prefetch-issued and prefetch-hit counters.

Function
REQ-013 SHALL hold a single prefetch buffer entry: buf_valid, buf_addr[27:0], buf_data[127:0].
REQ-014 SHALL implement states IDLE, FETCH, RESP, PREFETCH.
REQ-015 Memory handshake: in FETCH/PREFETCH, mem_read=1 and mem_addr SHALL be held stable until mem_ready is sampled high; mem_read SHALL be 0 in IDLE and RESP.
REQ-016 IDLE, ic_read=1, buf_valid=1, buf_addr==ic_addr (hit) -> RESP next cycle with ic_rdata=buf_data; pf_hit increments.
REQ-017 IDLE, ic_read=1, no hit -> FETCH with mem_addr=ic_addr; buf_valid cleared.
REQ-018 FETCH, mem_ready=1 -> capture mem_rdata, go to RESP.
REQ-019 RESP SHALL last exactly one cycle with ic_ready=1; ic_ready SHALL be 0 in all other states.
REQ-020 Leaving RESP: PF_ENABLE=1 -> PREFETCH with pf_addr = served address + 1 (28-bit wrap, 0xFFFFFFF -> 0x0000000), pf_issued increments; PF_ENABLE=0 -> IDLE.
REQ-021 PREFETCH, mem_ready=1, no pending request -> buf_data/buf_addr written, buf_valid=1, go to IDLE.
REQ-022 PREFETCH with ic_read=1 and ic_addr==pf_addr: on mem_ready, data SHALL be forwarded directly to RESP (counts as pf_hit; buffer is not written).
REQ-023 PREFETCH with ic_read=1 and ic_addr!=pf_addr: the outstanding transfer SHALL NOT be aborted; on mem_ready, data is discarded, buf_valid=0, go to FETCH for ic_addr.
REQ-024 Hit latency SHALL be 1 cycle from ic_read sampled in IDLE to ic_ready; miss latency SHALL be memory latency + 1 cycle.
REQ-025 Counters SHALL saturate at 0xFFFFFFFF.
REQ-026 ic_read/ic_addr SHALL only be sampled in IDLE and PREFETCH; no write path exists (icache never writes).

Reset
REQ-027 While proc_reset=0, all outputs SHALL be 0 immediately (asynchronously), state=IDLE, buf_valid=0, counters=0.
REQ-028 Reset asserted mid-transaction SHALL drop mem_read at once; a later mem_ready for the aborted request SHALL be ignored in IDLE.

Verification
REQ-029 Cold miss ic_addr=0x0000010, mem latency 4 -> mem_read at 0x0000010, ic_ready 1 cycle after mem_ready, then mem_read at 0x0000011, pf_issued=1.
REQ-030 Sequential: after REQ-029 prefetch completes, request 0x0000011 -> ic_ready next cycle with prefetched data, pf_hit=1, prefetch of 0x0000012 issued.
REQ-031 Request 0x0000011 while prefetch of 0x0000011 is pending -> ic_ready 1 cycle after mem_ready, no second memory read for 0x0000011.
REQ-032 Request 0x0000050 during prefetch of 0x0000011 -> prefetch completes and is discarded, then mem_read at 0x0000050, buf_valid=0.
REQ-033 Miss at 0xFFFFFFF -> prefetch address 0x0000000; PF_ENABLE=0 -> no prefetch, pf_issued stays 0.
REQ-034 proc_reset=0 during FETCH -> mem_read=0 and ic_ready=0 same cycle; after release, first request takes full miss path.

Source files
------------

// File: rtl/icache_prefetch.sv
// Single-entry next-line prefetcher between the instruction cache and main memory.
// Demand misses go straight to memory; each served line triggers a fetch of the following line.
module icache_prefetch #(
    parameter int PF_ENABLE = 1
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         ic_read,
    input  logic [27:0]  ic_addr,
    output logic [127:0] ic_rdata,
    output logic         ic_ready,
    output logic         mem_read,
    output logic [27:0]  mem_addr,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready,
    output logic [31:0]  pf_issued,
    output logic [31:0]  pf_hit
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FETCH    = 2'd1,
        S_RESP     = 2'd2,
        S_PREFETCH = 2'd3
    } state_t;

    localparam logic L_PF_ON = (PF_ENABLE != 0);

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        if (en && (v != 32'hFFFF_FFFF)) begin
            sat_inc = v + 32'd1;
        end else begin
            sat_inc = v;
        end
    endfunction

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_buf_valid;
    logic [27:0]    r_buf_addr;
    logic [127:0]   r_buf_data;
    logic [27:0]    r_req_addr;
    logic           r_ic_ready;
    logic [127:0]   r_ic_rdata;
    logic           r_mem_read;
    logic [27:0]    r_mem_addr;
    logic [31:0]    r_pf_issued;
    logic [31:0]    r_pf_hit;

    logic           w_buf_valid_nxt;
    logic [27:0]    w_buf_addr_nxt;
    logic [127:0]   w_buf_data_nxt;
    logic [27:0]    w_req_addr_nxt;
    logic           w_ic_ready_nxt;
    logic [127:0]   w_ic_rdata_nxt;
    logic           w_mem_read_nxt;
    logic [27:0]    w_mem_addr_nxt;
    logic           w_issue_inc;
    logic           w_hit_inc;

    // While in PREFETCH, r_mem_addr is the line being prefetched.
    logic w_hit;
    logic w_pf_match;
    assign w_hit      = ic_read && r_buf_valid && (r_buf_addr == ic_addr);
    assign w_pf_match = ic_read && (ic_addr == r_mem_addr);

    // State register.
    always_ff @(posedge clk or negedge proc_reset) begin
        if (!proc_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (ic_read) begin
                    w_state_nxt = w_hit ? S_RESP : S_FETCH;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FETCH: begin
                if (mem_ready) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_RESP: begin
                if (L_PF_ON) begin
                    w_state_nxt = S_PREFETCH;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PREFETCH: begin
                if (!mem_ready) begin
                    w_state_nxt = S_PREFETCH;
                end else if (!ic_read) begin
                    w_state_nxt = S_IDLE;
                end else if (w_pf_match) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath next values; outputs are registered so they align with the state they belong to.
    always_comb begin
        w_buf_valid_nxt = r_buf_valid;
        w_buf_addr_nxt  = r_buf_addr;
        w_buf_data_nxt  = r_buf_data;
        w_req_addr_nxt  = r_req_addr;
        w_ic_ready_nxt  = 1'b0;
        w_ic_rdata_nxt  = 128'd0;
        w_mem_read_nxt  = 1'b0;
        w_mem_addr_nxt  = 28'd0;
        w_issue_inc     = 1'b0;
        w_hit_inc       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ic_read) begin
                    w_req_addr_nxt = ic_addr;
                    if (w_hit) begin
                        w_ic_ready_nxt = 1'b1;
                        w_ic_rdata_nxt = r_buf_data;
                        w_hit_inc      = 1'b1;
                    end else begin
                        w_mem_read_nxt  = 1'b1;
                        w_mem_addr_nxt  = ic_addr;
                        w_buf_valid_nxt = 1'b0;
                    end
                end else begin
                    w_req_addr_nxt = r_req_addr;
                end
            end
            S_FETCH: begin
                if (mem_ready) begin
                    w_ic_ready_nxt = 1'b1;
                    w_ic_rdata_nxt = mem_rdata;
                end else begin
                    w_mem_read_nxt = 1'b1;
                    w_mem_addr_nxt = r_mem_addr;
                end
            end
            S_RESP: begin
                if (L_PF_ON) begin
                    w_mem_read_nxt = 1'b1;
                    w_mem_addr_nxt = r_req_addr + 28'd1;
                    w_issue_inc    = 1'b1;
                end else begin
                    w_mem_read_nxt = 1'b0;
                end
            end
            S_PREFETCH: begin
                if (!mem_ready) begin
                    w_mem_read_nxt = 1'b1;
                    w_mem_addr_nxt = r_mem_addr;
                end else if (!ic_read) begin
                    w_buf_valid_nxt = 1'b1;
                    w_buf_addr_nxt  = r_mem_addr;
                    w_buf_data_nxt  = mem_rdata;
                end else if (w_pf_match) begin
                    w_req_addr_nxt = ic_addr;
                    w_ic_ready_nxt = 1'b1;
                    w_ic_rdata_nxt = mem_rdata;
                    w_hit_inc      = 1'b1;
                end else begin
                    // Prefetched line is dropped; the demand address is fetched next.
                    w_req_addr_nxt  = ic_addr;
                    w_mem_read_nxt  = 1'b1;
                    w_mem_addr_nxt  = ic_addr;
                    w_buf_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_buf_valid_nxt = 1'b0;
            end
        endcase
    end

    // Datapath, counter and output registers.
    always_ff @(posedge clk or negedge proc_reset) begin
        if (!proc_reset) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= 28'd0;
            r_buf_data  <= 128'd0;
            r_req_addr  <= 28'd0;
            r_ic_ready  <= 1'b0;
            r_ic_rdata  <= 128'd0;
            r_mem_read  <= 1'b0;
            r_mem_addr  <= 28'd0;
            r_pf_issued <= 32'd0;
            r_pf_hit    <= 32'd0;
        end else begin
            r_buf_valid <= w_buf_valid_nxt;
            r_buf_addr  <= w_buf_addr_nxt;
            r_buf_data  <= w_buf_data_nxt;
            r_req_addr  <= w_req_addr_nxt;
            r_ic_ready  <= w_ic_ready_nxt;
            r_ic_rdata  <= w_ic_rdata_nxt;
            r_mem_read  <= w_mem_read_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_pf_issued <= sat_inc(r_pf_issued, w_issue_inc);
            r_pf_hit    <= sat_inc(r_pf_hit, w_hit_inc);
        end
    end

    assign ic_ready  = r_ic_ready;
    assign ic_rdata  = r_ic_rdata;
    assign mem_read  = r_mem_read;
    assign mem_addr  = r_mem_addr;
    assign pf_issued = r_pf_issued;
    assign pf_hit    = r_pf_hit;

endmodule

// File: tb/tb_icache_prefetch.sv
// Directed bench for icache_prefetch: one prefetching instance and one demand-only instance
// sharing clock, reset, address and memory-return inputs.
module tb_icache_prefetch;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         ic_read, ic0_read;
    logic [27:0]  ic_addr;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    logic [127:0] ic_rdata, ic0_rdata;
    logic         ic_ready, ic0_ready;
    logic         mem_read, mem0_read;
    logic [27:0]  mem_addr, mem0_addr;
    logic [31:0]  pf_issued, pf0_issued;
    logic [31:0]  pf_hit, pf0_hit;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    icache_prefetch #(.PF_ENABLE(1)) u_dut1 (
        .clk(clk), .proc_reset(proc_reset),
        .ic_read(ic_read), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_ready(ic_ready),
        .mem_read(mem_read), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pf_issued(pf_issued), .pf_hit(pf_hit)
    );

    icache_prefetch #(.PF_ENABLE(0)) u_dut0 (
        .clk(clk), .proc_reset(proc_reset),
        .ic_read(ic0_read), .ic_addr(ic_addr), .ic_rdata(ic0_rdata), .ic_ready(ic0_ready),
        .mem_read(mem0_read), .mem_addr(mem0_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pf_issued(pf0_issued), .pf_hit(pf0_hit)
    );

    function automatic logic [127:0] mk(input logic [27:0] a);
        mk = {4{4'hA, a}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory side: expects a held request for lat cycles, returns data on the last one.
    task automatic mem_serve(input string tag, input bit sel0, input logic [27:0] addr,
                             input logic [127:0] data, input int lat);
        for (int i = 0; i < lat; i++) begin
            chk({tag, ".rd"},   sel0 ? mem0_read : mem_read, 128'd1);
            chk({tag, ".addr"}, sel0 ? mem0_addr : mem_addr, {100'd0, addr});
            if (i == lat - 1) begin
                mem_ready = 1'b1;
                mem_rdata = data;
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        mem_rdata = 128'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        proc_reset = 1'b0;
        ic_read = 1'b0; ic0_read = 1'b0; ic_addr = 28'd0;
        mem_rdata = 128'd0; mem_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst.ic_ready", ic_ready, 128'd0);
        chk("rst.ic_rdata", ic_rdata, 128'd0);
        chk("rst.mem_read", mem_read, 128'd0);
        chk("rst.mem_addr", mem_addr, 128'd0);
        chk("rst.pf_issued", pf_issued, 128'd0);
        chk("rst.pf_hit", pf_hit, 128'd0);
        proc_reset = 1'b1;
        @(negedge clk);

        // Cold miss at 0x10, memory latency 4, then prefetch of 0x11
        ic_read = 1'b1; ic_addr = 28'h0000010;
        @(negedge clk);
        chk("cold.no_ready", ic_ready, 128'd0);
        mem_serve("cold", 1'b0, 28'h0000010, mk(28'h10), 4);
        chk("cold.ic_ready", ic_ready, 128'd1);
        chk("cold.ic_rdata", ic_rdata, mk(28'h10));
        chk("cold.mem_idle", mem_read, 128'd0);
        ic_read = 1'b0;
        @(negedge clk);
        chk("cold.ready_pulse", ic_ready, 128'd0);
        chk("cold.pf_issued", pf_issued, 128'd1);
        mem_serve("pf11", 1'b0, 28'h0000011, mk(28'h11), 2);
        chk("pf11.idle", mem_read, 128'd0);

        // Sequential hit on the buffered line
        ic_read = 1'b1; ic_addr = 28'h0000011;
        @(negedge clk);
        chk("seq.ic_ready", ic_ready, 128'd1);
        chk("seq.ic_rdata", ic_rdata, mk(28'h11));
        chk("seq.pf_hit", pf_hit, 128'd1);
        chk("seq.mem_idle", mem_read, 128'd0);
        ic_read = 1'b0;
        @(negedge clk);
        chk("seq.pf_issued", pf_issued, 128'd2);

        // Request the line currently being prefetched: forwarded, no second read
        ic_read = 1'b1; ic_addr = 28'h0000012;
        mem_serve("fwd", 1'b0, 28'h0000012, mk(28'h12), 3);
        chk("fwd.ic_ready", ic_ready, 128'd1);
        chk("fwd.ic_rdata", ic_rdata, mk(28'h12));
        chk("fwd.pf_hit", pf_hit, 128'd2);
        chk("fwd.no_refetch", mem_read, 128'd0);
        ic_read = 1'b0;
        @(negedge clk);
        chk("fwd.pf_issued", pf_issued, 128'd3);

        // Different request during prefetch of 0x13: prefetch discarded, then fetch 0x50
        ic_read = 1'b1; ic_addr = 28'h0000050;
        mem_serve("disc", 1'b0, 28'h0000013, mk(28'h13), 2);
        chk("disc.no_ready", ic_ready, 128'd0);
        chk("disc.buf_valid", u_dut1.r_buf_valid, 128'd0);
        mem_serve("m50", 1'b0, 28'h0000050, mk(28'h50), 3);
        chk("m50.ic_ready", ic_ready, 128'd1);
        chk("m50.ic_rdata", ic_rdata, mk(28'h50));
        chk("m50.pf_hit", pf_hit, 128'd2);
        ic_read = 1'b0;
        @(negedge clk);
        chk("m50.pf_issued", pf_issued, 128'd4);
        mem_serve("pf51", 1'b0, 28'h0000051, mk(28'h51), 1);

        // 0x13 was discarded, so it must miss
        ic_read = 1'b1; ic_addr = 28'h0000013;
        @(negedge clk);
        chk("re13.no_ready", ic_ready, 128'd0);
        mem_serve("re13", 1'b0, 28'h0000013, ~mk(28'h13), 1);
        chk("re13.ic_rdata", ic_rdata, ~mk(28'h13));
        ic_read = 1'b0;
        @(negedge clk);
        mem_serve("pf14", 1'b0, 28'h0000014, mk(28'h14), 1);

        // Address wrap: miss at 0xFFFFFFF prefetches 0x0000000
        ic_read = 1'b1; ic_addr = 28'hFFFFFFF;
        @(negedge clk);
        mem_serve("top", 1'b0, 28'hFFFFFFF, mk(28'hFFFFFFF), 2);
        chk("top.ic_rdata", ic_rdata, mk(28'hFFFFFFF));
        ic_read = 1'b0;
        @(negedge clk);
        chk("wrap.pf_issued", pf_issued, 128'd6);
        mem_serve("wrap", 1'b0, 28'h0000000, mk(28'h0), 1);
        ic_read = 1'b1; ic_addr = 28'h0000000;
        @(negedge clk);
        chk("wrap.hit_ready", ic_ready, 128'd1);
        chk("wrap.hit_rdata", ic_rdata, mk(28'h0));
        chk("wrap.pf_hit", pf_hit, 128'd3);
        ic_read = 1'b0;
        @(negedge clk);
        mem_serve("pf01", 1'b0, 28'h0000001, mk(28'h1), 1);

        // Reset during FETCH: outputs drop at once, stale mem_ready ignored
        ic_read = 1'b1; ic_addr = 28'h0000020;
        @(negedge clk);
        chk("rstf.mem_read", mem_read, 128'd1);
        @(negedge clk);
        proc_reset = 1'b0; ic_read = 1'b0;
        #1;
        chk("rstf.mem_read_drop", mem_read, 128'd0);
        chk("rstf.mem_addr", mem_addr, 128'd0);
        chk("rstf.ic_ready", ic_ready, 128'd0);
        chk("rstf.pf_issued", pf_issued, 128'd0);
        chk("rstf.pf_hit", pf_hit, 128'd0);
        @(negedge clk);
        proc_reset = 1'b1;
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = mk(28'h20);
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = 128'd0;
        chk("rstf.stale_ready", ic_ready, 128'd0);
        chk("rstf.stale_read", mem_read, 128'd0);
        // 0x11 was buffered-era data before reset; now it must take the full miss path
        ic_read = 1'b1; ic_addr = 28'h0000011;
        @(negedge clk);
        chk("post.no_hit", ic_ready, 128'd0);
        mem_serve("post", 1'b0, 28'h0000011, ~mk(28'h11), 2);
        chk("post.ic_rdata", ic_rdata, ~mk(28'h11));
        ic_read = 1'b0;
        @(negedge clk);
        chk("post.pf_issued", pf_issued, 128'd1);
        mem_serve("post_pf", 1'b0, 28'h0000012, mk(28'h12), 1);

        // Demand-only instance: no prefetch after a miss at 0xFFFFFFF
        ic0_read = 1'b1; ic_addr = 28'hFFFFFFF;
        @(negedge clk);
        mem_serve("pf0", 1'b1, 28'hFFFFFFF, mk(28'h5A), 2);
        chk("pf0.ic_ready", ic0_ready, 128'd1);
        chk("pf0.ic_rdata", ic0_rdata, mk(28'h5A));
        ic0_read = 1'b0;
        @(negedge clk);
        chk("pf0.no_pf_read", mem0_read, 128'd0);
        chk("pf0.pf_issued", pf0_issued, 128'd0);
        @(negedge clk);
        chk("pf0.still_idle", mem0_read, 128'd0);
        ic0_read = 1'b1; ic_addr = 28'h0000000;
        @(negedge clk);
        chk("pf0.miss_again", mem0_read, 128'd1);
        mem_serve("pf0b", 1'b1, 28'h0000000, mk(28'h0), 1);
        chk("pf0b.ic_ready", ic0_ready, 128'd1);
        chk("pf0b.pf_hit", pf0_hit, 128'd0);
        ic0_read = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
